hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 27 ++
 rtl/hazard_scoreboard.sv | 73 +++++++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_pkg
// Brief    : Shared constants and FSM state type for the issue hazard control.
// Revision : 1.0  initial release
// ============================================================================
package hazard_ctrl_pkg;

    localparam int NREG = 8;

    localparam int c_EAX = 0;
    localparam int c_ECX = 1;
    localparam int c_EDX = 2;
    localparam int c_EBX = 3;
    localparam int c_ESP = 4;
    localparam int c_EBP = 5;
    localparam int c_ESI = 6;
    localparam int c_EDI = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REFILL = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Per-GPR pending-write counters, RAW/WAW detect, busy/error flags.
// Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int NREG  = hazard_ctrl_pkg::NREG,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue,
    input  logic [NREG-1:0] src_mask,
    input  logic [NREG-1:0] dst_mask,
    input  logic            wb_valid,
    input  logic [NREG-1:0] wb_dst_mask,
    output logic            hazard,
    output logic            dst_full,
    output logic            sb_busy,
    output logic            sb_err
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [NREG-1:0] w_pending;
    logic [NREG-1:0] w_full;
    logic [NREG-1:0] w_bad;
    logic            r_err;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
            logic             w_inc;
            logic             w_dec;
            logic [CNT_W-1:0] r_cnt;

            assign w_inc         = issue & dst_mask[gi];
            assign w_dec         = wb_valid & wb_dst_mask[gi];
            assign w_pending[gi] = (r_cnt != '0);
            assign w_full[gi]    = (r_cnt == c_CNT_MAX);
            // Coincident inc/dec cancel; the counter saturates at both ends.
            assign w_bad[gi]     = (w_dec & ~w_inc & ~w_pending[gi])
                                 | (w_inc & ~w_dec & w_full[gi]);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_inc & ~w_dec & ~w_full[gi]) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (w_dec & ~w_inc & w_pending[gi]) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (|w_bad) begin
            r_err <= 1'b1;
        end
    end

    assign hazard   = |((src_mask | dst_mask) & w_pending);
    assign dst_full = |(dst_mask & w_full);
    assign sb_busy  = |w_pending;
    assign sb_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Decode issue control: scoreboard stalls plus mispredict flush FSM.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NREG       = hazard_ctrl_pkg::NREG,
    parameter int CNT_W      = 2,
    parameter int REFILL_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [NREG-1:0] id_src_mask,
    input  logic [NREG-1:0] id_dst_mask,
    input  logic            wb_valid,
    input  logic [NREG-1:0] wb_dst_mask,
    input  logic            ex_br_valid,
    input  logic            ex_br_mispredict,
    input  logic [31:0]     ex_br_target,
    output logic            stall,
    output logic            id_issue,
    output logic            flush,
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc,
    output logic            sb_busy,
    output logic            sb_err
);

    localparam int              c_RC_W    = $clog2(REFILL_CYC + 1);
    localparam logic [c_RC_W-1:0] c_RC_LOAD = c_RC_W'(REFILL_CYC - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_RC_W-1:0] r_refill_cnt;
    logic [c_RC_W-1:0] w_refill_nxt;
    logic              w_mispredict;
    logic              w_blocked;
    logic              w_hazard;
    logic              w_dst_full;
    logic              w_sb_busy;
    logic              w_sb_err;

    assign w_mispredict = ex_br_valid & ex_br_mispredict;

    hazard_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue       (id_issue),
        .src_mask    (id_src_mask),
        .dst_mask    (id_dst_mask),
        .wb_valid    (wb_valid),
        .wb_dst_mask (wb_dst_mask),
        .hazard      (w_hazard),
        .dst_full    (w_dst_full),
        .sb_busy     (w_sb_busy),
        .sb_err      (w_sb_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_refill_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_refill_cnt <= w_refill_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_refill_nxt   = r_refill_cnt;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        w_blocked      = 1'b0;
        id_issue       = 1'b0;
        stall          = 1'b0;

        // A new mispredict wins from any state, restarting the flush sequence.
        if (w_mispredict) begin
            w_state_nxt  = ST_FLUSH;
            w_refill_nxt = '0;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    w_state_nxt  = ST_REFILL;
                    w_refill_nxt = c_RC_LOAD;
                end
                ST_REFILL: begin
                    if (r_refill_cnt == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_refill_nxt = r_refill_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (!rst) begin
            flush          = w_mispredict | (r_state == ST_FLUSH);
            redirect_valid = w_mispredict;
            redirect_pc    = w_mispredict ? ex_br_target : '0;
            w_blocked      = w_hazard | w_dst_full | (r_state != ST_IDLE) | flush;
            id_issue       = id_valid & ~w_blocked;
            stall          = id_valid & w_blocked & ~flush;
        end
    end

    assign sb_busy = ~rst & w_sb_busy;
    assign sb_err  = ~rst & w_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed and randomized self-checking bench for hazard_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int NREG       = 8;
    localparam int CNT_W      = 2;
    localparam int REFILL_CYC = 2;
    localparam int c_MAX      = (1 << CNT_W) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            id_valid = 1'b0;
    logic [NREG-1:0] id_src_mask = '0;
    logic [NREG-1:0] id_dst_mask = '0;
    logic            wb_valid = 1'b0;
    logic [NREG-1:0] wb_dst_mask = '0;
    logic            ex_br_valid = 1'b0;
    logic            ex_br_mispredict = 1'b0;
    logic [31:0]     ex_br_target = '0;
    logic            stall;
    logic            id_issue;
    logic            flush;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            sb_busy;
    logic            sb_err;

    int n_vec = 0;
    int n_mis = 0;
    int cyc_n = 0;

    // Reference model: pending writes per register, sticky error, and the
    // number of cycles issue remains blocked after a redirect.
    int pend [NREG];
    bit m_err = 1'b0;
    bit flush_next = 1'b0;
    int block_left = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .NREG       (NREG),
        .CNT_W      (CNT_W),
        .REFILL_CYC (REFILL_CYC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_src_mask      (id_src_mask),
        .id_dst_mask      (id_dst_mask),
        .wb_valid         (wb_valid),
        .wb_dst_mask      (wb_dst_mask),
        .ex_br_valid      (ex_br_valid),
        .ex_br_mispredict (ex_br_mispredict),
        .ex_br_target     (ex_br_target),
        .stall            (stall),
        .id_issue         (id_issue),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .sb_busy          (sb_busy),
        .sb_err           (sb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc_n);
        end
    endtask

    function automatic logic [NREG-1:0] pend_mask();
        logic [NREG-1:0] m;
        m = '0;
        for (int i = 0; i < NREG; i++) m[i] = (pend[i] != 0);
        return m;
    endfunction

    // Called one time unit after a rising edge with inputs already driven.
    task automatic step();
        bit mp, e_flush, haz, blocked, e_issue, e_stall, busy, inc, dec;
        #1;
        mp  = ex_br_valid && ex_br_mispredict;
        haz = 1'b0;
        busy = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (pend[i] != 0) begin
                busy = 1'b1;
                if (id_src_mask[i] || id_dst_mask[i]) haz = 1'b1;
            end
            if (id_dst_mask[i] && pend[i] == c_MAX) haz = 1'b1;
        end
        e_flush = !rst && (mp || flush_next);
        blocked = haz || (block_left > 0) || e_flush;
        e_issue = !rst && id_valid && !blocked;
        e_stall = !rst && id_valid && blocked && !e_flush;

        chk("stall",          stall,          e_stall);
        chk("id_issue",       id_issue,       e_issue);
        chk("flush",          flush,          e_flush);
        chk("redirect_valid", redirect_valid, !rst && mp);
        chk("redirect_pc",    redirect_pc,    (!rst && mp) ? ex_br_target : 32'h0);
        chk("sb_busy",        sb_busy,        !rst && busy);
        chk("sb_err",         sb_err,         !rst && m_err);

        if (rst) begin
            for (int i = 0; i < NREG; i++) pend[i] = 0;
            m_err = 1'b0;
            flush_next = 1'b0;
            block_left = 0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                inc = e_issue && id_dst_mask[i];
                dec = wb_valid && wb_dst_mask[i];
                if (inc && !dec) begin
                    pend[i]++;
                end else if (dec && !inc) begin
                    if (pend[i] == 0) m_err = 1'b1;
                    else pend[i]--;
                end
            end
            if (mp) begin
                flush_next = 1'b1;
                block_left = 1 + REFILL_CYC;
            end else begin
                flush_next = 1'b0;
                if (block_left > 0) block_left--;
            end
        end
        @(posedge clk);
        cyc_n++;
        #1;
    endtask

    task automatic cyc(input logic v, input logic [7:0] src, input logic [7:0] dst,
                       input logic wv, input logic [7:0] wbm,
                       input logic bv, input logic bm, input logic [31:0] tgt);
        id_valid = v;  id_src_mask = src; id_dst_mask = dst;
        wb_valid = wv; wb_dst_mask = wbm;
        ex_br_valid = bv; ex_br_mispredict = bm; ex_br_target = tgt;
        step();
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) pend[i] = 0;

        rst = 1'b1;
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 32'h0);
        cyc(1, 8'h01, 8'h01, 1, 8'h01, 1, 1, 32'h1234);
        rst = 1'b0;

        // Back-to-back RAW on EAX, released by writeback one cycle later.
        cyc(1, 8'h00, 8'h01, 0, 8'h00, 0, 0, 32'h0);
        repeat (3) cyc(1, 8'h01, 8'h00, 0, 8'h00, 0, 0, 32'h0);
        cyc(1, 8'h01, 8'h00, 1, 8'h01, 0, 0, 32'h0);
        cyc(1, 8'h01, 8'h00, 0, 8'h00, 0, 0, 32'h0);

        // Independent ops issue back to back, then drain.
        cyc(1, 8'h00, 8'h01, 0, 8'h00, 0, 0, 32'h0);
        cyc(1, 8'h02, 8'h04, 0, 8'h00, 0, 0, 32'h0);
        cyc(0, 8'h00, 8'h00, 1, 8'h05, 0, 0, 32'h0);

        // Mispredict with target 0x20, correctly predicted branch no effect.
        cyc(1, 8'h00, 8'h00, 0, 8'h00, 1, 0, 32'h0000_0010);
        cyc(1, 8'h00, 8'h00, 0, 8'h00, 1, 1, 32'h0000_0020);
        repeat (4) cyc(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 32'h0);

        // Same-cycle issue and writeback to ECX.
        cyc(1, 8'h00, 8'h02, 1, 8'h02, 0, 0, 32'h0);
        cyc(1, 8'h02, 8'h00, 0, 8'h00, 0, 0, 32'h0);

        // Repeated writes to EBX, release, drain, then underflow.
        repeat (4) cyc(1, 8'h00, 8'h08, 0, 8'h00, 0, 0, 32'h0);
        cyc(1, 8'h00, 8'h08, 1, 8'h08, 0, 0, 32'h0);
        cyc(1, 8'h00, 8'h08, 0, 8'h00, 0, 0, 32'h0);
        cyc(0, 8'h00, 8'h00, 1, 8'h08, 0, 0, 32'h0);
        cyc(0, 8'h00, 8'h00, 1, 8'h08, 0, 0, 32'h0);
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 32'h0);

        // Second mispredict during REFILL, newest target wins.
        cyc(1, 8'h00, 8'h00, 0, 8'h00, 1, 1, 32'h0000_0040);
        cyc(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 32'h0);
        cyc(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 32'h0);
        cyc(1, 8'h00, 8'h00, 0, 8'h00, 1, 1, 32'h0000_0080);
        repeat (5) cyc(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 32'h0);

        // Reset during FLUSH with EAX pending.
        cyc(1, 8'h00, 8'h01, 0, 8'h00, 0, 0, 32'h0);
        cyc(1, 8'h00, 8'h00, 0, 8'h00, 1, 1, 32'h0000_0100);
        rst = 1'b1;
        cyc(1, 8'h01, 8'h00, 0, 8'h00, 0, 0, 32'h0);
        rst = 1'b0;
        cyc(1, 8'h01, 8'h00, 0, 8'h00, 0, 0, 32'h0);
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 32'h0);

        // Randomized traffic; writebacks only retire outstanding writes.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] dst;
            logic       bv;
            dst = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            bv  = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 3) != 0,
                8'($urandom) & 8'($urandom),
                dst,
                $urandom_range(0, 1) == 1,
                8'($urandom) & pend_mask(),
                bv,
                bv && ($urandom_range(0, 1) == 1),
                $urandom);
        end
        rst = 1'b0;
        cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
